// File: rtl/cpu_status_pkg.sv
// cpu_status_pkg: shared definitions for the 6502 processor status block.
//   - FLAG_* : bit positions of each flag inside the P byte
//   - P_RESET: P as read right after reset (I=1, bits 5/4 read 1)
//   - flags_t: the six stored flags
//   - pack_p : build a P byte from stored flags and a B-bit value
package cpu_status_pkg;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_B = 4;
    localparam int FLAG_U = 5;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    localparam logic [7:0] P_RESET = 8'h34;

    typedef struct packed {
        logic n;
        logic v;
        logic d;
        logic i;
        logic z;
        logic c;
    } flags_t;

    localparam flags_t FLAGS_RESET = '{n: 1'b0, v: 1'b0, d: 1'b0, i: 1'b1, z: 1'b0, c: 1'b0};

    // Bit 5 always reads 1; bit 4 is supplied by the caller (1 for live P).
    function automatic logic [7:0] pack_p(flags_t f, logic b);
        logic [7:0] p;
        p         = 8'h00;
        p[FLAG_N] = f.n;
        p[FLAG_V] = f.v;
        p[FLAG_U] = 1'b1;
        p[FLAG_B] = b;
        p[FLAG_D] = f.d;
        p[FLAG_I] = f.i;
        p[FLAG_Z] = f.z;
        p[FLAG_C] = f.c;
        return p;
    endfunction

endpackage

// File: rtl/cpu_status_if.sv
// cpu_status_if: bundle between the control unit / ALU (master) and the
// processor status block (slave).
//   master drives: ALU flags, update strobes, BIT, explicit flag writes,
//                  PLP/RTI load, brk_push, sync, interrupt lines, int_ack
//   slave drives : p_out, p_push, carry, decimal, irq_pending, nmi_pending
interface cpu_status_if;
    logic       alu_neg, alu_ov, alu_zero, alu_carry;
    logic       upd_n, upd_v, upd_z, upd_c;
    logic       bit_load;
    logic [7:0] data_in;
    logic       set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v;
    logic       p_load;
    logic [7:0] p_in;
    logic       brk_push;
    logic       sync;
    logic       irq_n, nmi_n;
    logic       int_ack;
    logic [7:0] p_out, p_push;
    logic       carry, decimal;
    logic       irq_pending, nmi_pending;

    modport master (
        output alu_neg, alu_ov, alu_zero, alu_carry,
        output upd_n, upd_v, upd_z, upd_c, bit_load, data_in,
        output set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v,
        output p_load, p_in, brk_push, sync, irq_n, nmi_n, int_ack,
        input  p_out, p_push, carry, decimal, irq_pending, nmi_pending
    );

    modport slave (
        input  alu_neg, alu_ov, alu_zero, alu_carry,
        input  upd_n, upd_v, upd_z, upd_c, bit_load, data_in,
        input  set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v,
        input  p_load, p_in, brk_push, sync, irq_n, nmi_n, int_ack,
        output p_out, p_push, carry, decimal, irq_pending, nmi_pending
    );
endinterface

// File: rtl/cpu_nmi_edge.sv
// cpu_nmi_edge: NMI falling-edge detector and latch.
//   clk, rst   : clock, async active-high reset
//   nmi_n      : active-low NMI, already synchronous to clk
//   int_ack    : interrupt sequence entered, clears the latch
//   nmi_latch  : set by a 1->0 transition of nmi_n, held until int_ack
module cpu_nmi_edge (
    input  logic clk,
    input  logic rst,
    input  logic nmi_n,
    input  logic int_ack,
    output logic nmi_latch
);
    logic prev_q, prev_d;
    logic latch_q, latch_d;
    logic nmi_edge;

    // prev resets to 0, so a line held low across reset release never
    // looks like a falling edge.
    assign nmi_edge = prev_q & ~nmi_n;

    always_comb begin
        prev_d  = nmi_n;
        latch_d = latch_q;
        if (nmi_edge)
            latch_d = 1'b1;   // a new edge beats a same-cycle ack
        else if (int_ack)
            latch_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            latch_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            latch_q <= latch_d;
        end
    end

    assign nmi_latch = latch_q;
endmodule

// File: rtl/cpu_status.sv
// cpu_status: 6502 processor status (P) register and interrupt recognition.
//   clk, rst : clock, async active-high reset
//   bus      : cpu_status_if.slave (ALU flags, strobes, PLP load, push byte,
//              carry/decimal feedback, irq/nmi pending)
// Build option: CPU_STATUS_DECIMAL_EN stores the D flag; without it D reads
// 0 and set_d/clr_d/p_in[3] are ignored (2A03-style core).
module cpu_status
    import cpu_status_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    cpu_status_if.slave  bus
);
    flags_t flags_q, flags_d;
    logic   irq_pending_q, irq_pending_d;
    logic   nmi_pending_q, nmi_pending_d;
    logic   nmi_latch;

    cpu_nmi_edge u_nmi_edge (
        .clk       (clk),
        .rst       (rst),
        .nmi_n     (bus.nmi_n),
        .int_ack   (bus.int_ack),
        .nmi_latch (nmi_latch)
    );

    // Per-flag priority: stack load, explicit set (beats clr), explicit clr,
    // BIT, ALU update, hold.
    always_comb begin
        flags_d = flags_q;

        if (bus.p_load)       flags_d.c = bus.p_in[FLAG_C];
        else if (bus.set_c)   flags_d.c = 1'b1;
        else if (bus.clr_c)   flags_d.c = 1'b0;
        else if (bus.upd_c)   flags_d.c = bus.alu_carry;

        if (bus.p_load)       flags_d.z = bus.p_in[FLAG_Z];
        else if (bus.upd_z)   flags_d.z = bus.alu_zero;

        if (bus.p_load)       flags_d.i = bus.p_in[FLAG_I];
        else if (bus.set_i)   flags_d.i = 1'b1;
        else if (bus.clr_i)   flags_d.i = 1'b0;

        if (bus.p_load)        flags_d.v = bus.p_in[FLAG_V];
        else if (bus.clr_v)    flags_d.v = 1'b0;
        else if (bus.bit_load) flags_d.v = bus.data_in[6];
        else if (bus.upd_v)    flags_d.v = bus.alu_ov;

        if (bus.p_load)        flags_d.n = bus.p_in[FLAG_N];
        else if (bus.bit_load) flags_d.n = bus.data_in[7];
        else if (bus.upd_n)    flags_d.n = bus.alu_neg;

`ifdef CPU_STATUS_DECIMAL_EN
        if (bus.p_load)       flags_d.d = bus.p_in[FLAG_D];
        else if (bus.set_d)   flags_d.d = 1'b1;
        else if (bus.clr_d)   flags_d.d = 1'b0;
`else
        flags_d.d = 1'b0;
`endif
    end

    // Pending flags only move at instruction boundaries. IRQ uses the
    // registered I, so CLI/SEI affect recognition one instruction late.
    always_comb begin
        irq_pending_d = irq_pending_q;
        nmi_pending_d = nmi_pending_q;
        if (bus.int_ack) begin
            irq_pending_d = 1'b0;
            nmi_pending_d = 1'b0;
        end else if (bus.sync) begin
            irq_pending_d = ~bus.irq_n & ~flags_q.i;
            nmi_pending_d = nmi_latch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q       <= FLAGS_RESET;
            irq_pending_q <= 1'b0;
            nmi_pending_q <= 1'b0;
        end else begin
            flags_q       <= flags_d;
            irq_pending_q <= irq_pending_d;
            nmi_pending_q <= nmi_pending_d;
        end
    end

    assign bus.p_out       = pack_p(flags_q, 1'b1);
    assign bus.p_push      = pack_p(flags_q, bus.brk_push);
    assign bus.carry       = flags_q.c;
    assign bus.irq_pending = irq_pending_q;
    assign bus.nmi_pending = nmi_pending_q;

`ifdef CPU_STATUS_DECIMAL_EN
    assign bus.decimal = flags_q.d;
    logic unused_bits;
    assign unused_bits = ^bus.p_in[FLAG_U:FLAG_B];
`else
    assign bus.decimal = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{bus.p_in[FLAG_U:FLAG_D], bus.set_d, bus.clr_d};
`endif
endmodule

// File: tb/tb_cpu_status.sv
// tb_cpu_status: directed + randomized bench for cpu_status. The reference
// model keeps P as a plain byte and applies writes in increasing priority
// order, so the last write standing is the winner.
module tb_cpu_status;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_status_if bus();
    cpu_status dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;

`ifdef CPU_STATUS_DECIMAL_EN
    localparam logic [7:0] STORED   = 8'hCF;
    localparam logic [7:0] PLP_OUT  = 8'hFF;
    localparam logic [7:0] PLP_PUSH = 8'hEF;
`else
    localparam logic [7:0] STORED   = 8'hC7;
    localparam logic [7:0] PLP_OUT  = 8'hF7;
    localparam logic [7:0] PLP_PUSH = 8'hE7;
`endif

    // reference state
    logic [7:0] m_p;
    logic m_prev, m_latch, m_irqp, m_nmip;

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".p_out"},  bus.p_out,  m_p | 8'h30);
        chk({tag, ".p_push"}, bus.p_push, (m_p | 8'h20) | {3'b000, bus.brk_push, 4'h0});
        chk({tag, ".carry"},  {7'd0, bus.carry},   {7'd0, m_p[0]});
        chk({tag, ".dec"},    {7'd0, bus.decimal}, {7'd0, m_p[3]});
        chk({tag, ".irqp"},   {7'd0, bus.irq_pending}, {7'd0, m_irqp});
        chk({tag, ".nmip"},   {7'd0, bus.nmi_pending}, {7'd0, m_nmip});
    endtask

    task automatic model_reset();
        m_p = 8'h04; m_prev = 1'b0; m_latch = 1'b0; m_irqp = 1'b0; m_nmip = 1'b0;
    endtask

    task automatic model_step();
        logic [7:0] np;
        logic nedge;
        np = m_p;
        if (bus.upd_c) np[0] = bus.alu_carry;
        if (bus.upd_z) np[1] = bus.alu_zero;
        if (bus.upd_v) np[6] = bus.alu_ov;
        if (bus.upd_n) np[7] = bus.alu_neg;
        if (bus.bit_load) np[7:6] = bus.data_in[7:6];
        if (bus.clr_c) np[0] = 1'b0;
        if (bus.clr_i) np[2] = 1'b0;
        if (bus.clr_d) np[3] = 1'b0;
        if (bus.clr_v) np[6] = 1'b0;
        if (bus.set_c) np[0] = 1'b1;
        if (bus.set_i) np[2] = 1'b1;
        if (bus.set_d) np[3] = 1'b1;
        if (bus.p_load) np = bus.p_in;
        np = np & STORED;
        nedge = m_prev & ~bus.nmi_n;
        if (bus.int_ack) begin
            m_irqp = 1'b0; m_nmip = 1'b0;
        end else if (bus.sync) begin
            m_nmip = m_latch;
            m_irqp = ~bus.irq_n & ~m_p[2];
        end
        if (nedge) m_latch = 1'b1;
        else if (bus.int_ack) m_latch = 1'b0;
        m_prev = bus.nmi_n;
        m_p = np;
    endtask

    task automatic idle();
        {bus.alu_neg, bus.alu_ov, bus.alu_zero, bus.alu_carry} = 4'h0;
        {bus.upd_n, bus.upd_v, bus.upd_z, bus.upd_c} = 4'h0;
        bus.bit_load = 1'b0; bus.data_in = 8'h00;
        {bus.set_c, bus.clr_c, bus.set_i, bus.clr_i, bus.set_d, bus.clr_d, bus.clr_v} = 7'h0;
        bus.p_load = 1'b0; bus.p_in = 8'h00; bus.brk_push = 1'b0;
        bus.sync = 1'b0; bus.int_ack = 1'b0;
    endtask

    // Model consumes the inputs present before the edge; outputs checked 1ns after.
    task automatic tick(string tag);
        if (rst) model_reset(); else model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.irq_n = 1'b1;
        bus.nmi_n = 1'b1;
        model_reset();
        #2;
        tick("reset");
        chk("reset.p_out_const",  bus.p_out,  8'h34);
        chk("reset.p_push_const", bus.p_push, 8'h24);
        rst = 1'b0;

        // set beats nothing here; clr_c beats the ALU update
        bus.upd_c = 1'b1; bus.alu_carry = 1'b1; bus.clr_c = 1'b1;
        tick("clr_over_upd");
        chk("clr_over_upd.c", {7'd0, bus.carry}, 8'h00);
        idle();
        bus.upd_n = 1'b1; bus.upd_z = 1'b1; bus.alu_neg = 1'b1; bus.alu_zero = 1'b0;
        tick("upd_nz");
        chk("upd_nz.const", bus.p_out, 8'hB4);
        idle();

        // set and clr together: set wins
        bus.set_c = 1'b1; bus.clr_c = 1'b1;
        tick("set_wins");
        idle();

        // PLP / push byte
        bus.p_load = 1'b1; bus.p_in = 8'hCF;
        tick("plp");
        chk("plp.const", bus.p_out, PLP_OUT);
        chk("push.const", bus.p_push, PLP_PUSH);
        idle();

        // CLI delay: I=1 from PLP, irq line low
        bus.irq_n = 1'b0; bus.sync = 1'b1; bus.clr_i = 1'b1;
        tick("cli_sync");
        chk("cli_sync.irqp", {7'd0, bus.irq_pending}, 8'h00);
        idle(); bus.sync = 1'b1;
        tick("next_sync");
        chk("next_sync.irqp", {7'd0, bus.irq_pending}, 8'h01);
        idle(); bus.int_ack = 1'b1;
        tick("irq_ack");
        idle(); bus.irq_n = 1'b1;

        // NMI edge in same cycle as ack: edge wins
        bus.nmi_n = 1'b0; bus.int_ack = 1'b1;
        tick("nmi_edge_ack");
        chk("nmi_edge_ack.latch", {7'd0, dut.nmi_latch}, {7'd0, m_latch});
        idle(); bus.sync = 1'b1;
        tick("nmi_sync");
        chk("nmi_sync.nmip", {7'd0, bus.nmi_pending}, 8'h01);
        idle(); bus.int_ack = 1'b1;
        tick("nmi_ack");
        idle(); bus.sync = 1'b1;
        tick("nmi_held1");
        tick("nmi_held2");
        chk("nmi_held.nmip", {7'd0, bus.nmi_pending}, 8'h00);
        idle();

        // reset with nmi_n held low: no edge at release
        rst = 1'b1;
        model_reset();
        tick("rst_nmi_low");
        rst = 1'b0;
        bus.sync = 1'b1;
        tick("rel1");
        tick("rel2");
        chk("rst_nmi_low.nmip", {7'd0, bus.nmi_pending}, 8'h00);
        idle(); bus.nmi_n = 1'b1;

        // asynchronous reset mid-cycle
        bus.set_c = 1'b1; bus.p_load = 1'b1; bus.p_in = 8'hC3;
        tick("pre_async");
        idle();
        #3 rst = 1'b1;
        model_reset();
        #1 check_all("async_rst");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // randomized phase
        for (int n = 0; n < 400; n++) begin
            bus.alu_neg   = 1'($urandom);
            bus.alu_ov    = 1'($urandom);
            bus.alu_zero  = 1'($urandom);
            bus.alu_carry = 1'($urandom);
            bus.upd_n = ($urandom_range(3) == 0);
            bus.upd_v = ($urandom_range(3) == 0);
            bus.upd_z = ($urandom_range(3) == 0);
            bus.upd_c = ($urandom_range(3) == 0);
            bus.bit_load = ($urandom_range(7) == 0);
            bus.data_in  = 8'($urandom);
            bus.set_c = ($urandom_range(7) == 0);
            bus.clr_c = ($urandom_range(7) == 0);
            bus.set_i = ($urandom_range(7) == 0);
            bus.clr_i = ($urandom_range(5) == 0);
            bus.set_d = ($urandom_range(7) == 0);
            bus.clr_d = ($urandom_range(7) == 0);
            bus.clr_v = ($urandom_range(7) == 0);
            bus.p_load = ($urandom_range(15) == 0);
            bus.p_in   = 8'($urandom);
            bus.brk_push = 1'($urandom);
            bus.sync = ($urandom_range(2) == 0);
            bus.int_ack = !bus.sync && ($urandom_range(9) == 0);
            if ($urandom_range(3) == 0) bus.irq_n = ~bus.irq_n;
            if ($urandom_range(5) == 0) bus.nmi_n = ~bus.nmi_n;
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
